// File: rtl/freq_div_pkg.sv
// Shared types and constants for the programmable clock-enable divider.
package freq_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_t;

    localparam int unsigned MIN_DIV = 1;

endpackage

// File: rtl/freq_div_reload.sv
// Single-entry reload buffer: valid/ready handshake, divisor clamp, and apply strobe.
module freq_div_reload
    import freq_div_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] load_div,
    input  logic             load_mode,
    input  logic             apply_req,
    output logic             load_ready,
    output logic             apply_pending,
    output logic [CNT_W-1:0] pending_div,
    output logic             pending_mode
);

    logic             pending_q, pending_d;
    logic [CNT_W-1:0] pending_div_q, pending_div_d;
    mode_t            pending_mode_q, pending_mode_d;
    logic             accept;

    // Accept and apply are mutually exclusive: accept needs an empty buffer, apply a full one.
    always_comb begin
        accept         = load_valid & ~pending_q;
        apply_pending  = pending_q & apply_req;
        pending_d      = pending_q;
        pending_div_d  = pending_div_q;
        pending_mode_d = pending_mode_q;
        if (apply_pending) begin
            pending_d = 1'b0;
        end
        if (accept) begin
            pending_d      = 1'b1;
            pending_div_d  = (load_div == '0) ? CNT_W'(MIN_DIV) : load_div;
            pending_mode_d = mode_t'(load_mode);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q      <= 1'b0;
            pending_div_q  <= CNT_W'(MIN_DIV);
            pending_mode_q <= MODE_TOGGLE;
        end else begin
            pending_q      <= pending_d;
            pending_div_q  <= pending_div_d;
            pending_mode_q <= pending_mode_d;
        end
    end

    assign load_ready   = ~pending_q;
    assign pending_div  = pending_div_q;
    assign pending_mode = pending_mode_q;

endmodule

// File: rtl/freq_divider_prog.sv
// Runtime-programmable clock-enable divider with square/pulse output and binary prescaler taps.
module freq_divider_prog
    import freq_div_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TAP_W       = 3,
    parameter int unsigned DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [CNT_W-1:0] load_div,
    input  logic             load_mode,
    output logic             out,
    output logic             tick,
    output logic [TAP_W-1:0] taps,
    output logic [CNT_W-1:0] active_div
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    mode_t            mode_q, mode_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic [TAP_W-1:0] taps_q, taps_d;

    logic             term;
    logic             apply_pending;
    logic [CNT_W-1:0] pending_div;
    logic             pending_mode;
    mode_t            next_mode;

    freq_div_reload #(.CNT_W(CNT_W)) u_reload (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_div     (load_div),
        .load_mode    (load_mode),
        .apply_req    (term | ~en),
        .load_ready   (load_ready),
        .apply_pending(apply_pending),
        .pending_div  (pending_div),
        .pending_mode (pending_mode)
    );

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        term      = en & (cnt_q == div_q - CNT_W'(1));
        next_mode = apply_pending ? mode_t'(pending_mode) : mode_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        mode_d    = mode_q;
        out_d     = out_q;
        tick_d    = term;
        taps_d    = en ? taps_q + TAP_W'(1) : taps_q;

        // The output reacts in the mode that governs the period starting at this edge.
        if (!en) begin
            if (mode_q == MODE_PULSE) out_d = 1'b0;
        end else if (term) begin
            out_d = (next_mode == MODE_PULSE) ? 1'b1 : ~out_q;
        end else if (mode_q == MODE_PULSE) begin
            out_d = 1'b0;
        end

        if (apply_pending) begin
            cnt_d  = '0;
            div_d  = pending_div;
            mode_d = next_mode;
        end else if (en) begin
            cnt_d = term ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: the async reset restores the power-up divisor and drops any half-programmed state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            div_q  <= CNT_W'(DEFAULT_DIV);
            mode_q <= MODE_TOGGLE;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
            taps_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            mode_q <= mode_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            taps_q <= taps_d;
        end
    end

    assign out        = out_q;
    assign tick       = tick_q;
    assign taps       = taps_q;
    assign active_div = div_q;

endmodule
